// File: rtl/fetch_controller_if.sv
// rtl/fetch_controller_if.sv - instruction memory request/response bus for fetch_controller
interface fetch_controller_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - IF-stage fetch sequencer with hold buffer and branch flush
// Optional performance counters built when IFU_PERF_CNT_EN is defined.
module fetch_controller #(
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                freeze,
    input  logic                branch_taken,
    input  logic [31:0]         branch_addr,
    fetch_controller_if.master  mem,
    output logic                if_valid,
    output logic [31:0]         if_instr,
    output logic [31:0]         if_pc,
    output logic                busy
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]         fetch_count,
    output logic [31:0]         stall_count
`endif
);

    typedef enum logic [1:0] {WAIT_RST, FETCH, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] pc_inc;

    assign pc_inc = pc_q + 32'd4;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        if_valid_d  = if_valid_q;
        if_instr_d  = if_instr_q;
        if_pc_d     = if_pc_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        case (state_q)
            WAIT_RST: state_d = FETCH;
            FETCH, HOLD: begin
                // A redirect wins over everything, including a word returning this cycle.
                if (branch_taken) begin
                    state_d     = FETCH;
                    pc_d        = branch_addr & 32'hFFFF_FFFC;
                    if_valid_d  = 1'b0;
                    buf_instr_d = 32'd0;
                    buf_pc_d    = 32'd0;
                end else if (state_q == FETCH) begin
                    if (mem.mem_ready) begin
                        pc_d = pc_inc;
                        if (freeze) begin
                            buf_instr_d = mem.mem_rdata;
                            buf_pc_d    = pc_inc;
                            state_d     = HOLD;
                        end else begin
                            if_instr_d = mem.mem_rdata;
                            if_pc_d    = pc_inc;
                            if_valid_d = 1'b1;
                        end
                    end else if (!freeze) begin
                        if_valid_d = 1'b0;
                    end
                end else if (!freeze) begin
                    if_instr_d = buf_instr_q;
                    if_pc_d    = buf_pc_q;
                    if_valid_d = 1'b1;
                    state_d    = FETCH;
                end
            end
            default: state_d = WAIT_RST;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_RST;
            pc_q        <= RESET_PC;
            if_valid_q  <= 1'b0;
            if_instr_q  <= 32'd0;
            if_pc_q     <= 32'd0;
            buf_instr_q <= 32'd0;
            buf_pc_q    <= 32'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            if_valid_q  <= if_valid_d;
            if_instr_q  <= if_instr_d;
            if_pc_q     <= if_pc_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
        end
    end

    assign mem.mem_req  = (state_q == FETCH);
    assign mem.mem_addr = pc_q;
    assign if_valid     = if_valid_q;
    assign if_instr     = if_instr_q;
    assign if_pc        = if_pc_q;
    assign busy         = (state_q != FETCH) || !mem.mem_ready;

`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q;
        stall_count_d = stall_count_q;
        if (state_q == FETCH && mem.mem_ready && !branch_taken)
            fetch_count_d = fetch_count_q + 32'd1;
        if ((state_q == FETCH && !mem.mem_ready) || state_q == HOLD)
            stall_count_d = stall_count_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count_q <= 32'd0;
            stall_count_q <= 32'd0;
        end else begin
            fetch_count_q <= fetch_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Instruction-fetch sequencer for the IF stage. Owns the program counter, issues word addresses to the instruction memory, and captures returned words into the IF/ID boundary registers. It handles:

- memory wait states, through a ready handshake;
- downstream freeze, using a one-entry hold buffer;
- taken branches, with a flush.

It sits between the hazard/branch logic and the instruction memory. It is the only block that drives the memory address.

## Interface

Parameters:

- RESET_PC, 32'd0, PC value loaded on reset; bits [1:0] must be 00.

Ports:

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- freeze  in  1  downstream stall; IF/ID outputs must hold
- branch_taken  in  1  redirect fetch this cycle
- branch_addr  in  32  redirect target; bits [1:0] ignored, treated as 00
- mem_req  out  1  fetch request valid
- mem_addr  out  32  word address; always equals the pc register
- mem_ready  in  1  mem_rdata valid for mem_addr this cycle; memory may be combinational, with ready tied high
- mem_rdata  in  32  instruction word
- if_valid  out  1  if_instr/if_pc hold a real instruction
- if_instr  out  32  fetched instruction
- if_pc  out  32  address of fetched instruction + 4
- busy  out  1  high when state is not FETCH, or when FETCH has mem_req high and mem_ready low

## Operation

- States: WAIT_RST, FETCH, HOLD.
- Reset (rst_n low, asynchronous) sets:
  - state WAIT_RST, pc=RESET_PC;
  - if_valid=0, if_instr=0, if_pc=0;
  - hold buffer cleared, mem_req=0.
- WAIT_RST:
  - mem_req=0.
  - Unconditionally moves to FETCH on the next edge.
- FETCH: mem_req=1, mem_addr=pc. Per edge:
  - mem_ready=1 and freeze=0: if_instr<=mem_rdata, if_pc<=pc+4, if_valid<=1, pc<=pc+4.
  - mem_ready=1 and freeze=1: buffer<=(mem_rdata, pc+4), pc<=pc+4, go to HOLD; if_* unchanged.
  - mem_ready=0 and freeze=0: if_valid<=0 (bubble); if_instr/if_pc unchanged.
  - mem_ready=0 and freeze=1: all outputs hold.
- HOLD:
  - mem_req=0.
  - freeze=1: stay.
  - freeze=0: if_* <= buffer, if_valid<=1, go to FETCH.
- branch_taken has highest priority in every state except WAIT_RST, where it is ignored. On the edge where it is asserted:
  - pc<={branch_addr[31:2],2'b00}, state<=FETCH, buffer discarded;
  - if_valid<=0 even if freeze=1 (flush overrides freeze);
  - a word returned that same cycle is dropped.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 wraps to 0 with no flag.
- If rst_n is asserted mid-operation, including mid-wait or in HOLD, the reset values above apply immediately. Any outstanding request is abandoned with no residual state.

## Timing

- Reset release before edge 0. mem_req rises after edge 0, with mem_addr=RESET_PC.
- With mem_ready=1, the first if_valid=1 appears after edge 1.
- Steady-state throughput is 1 instruction/cycle with mem_ready=1 and freeze=0.
- Fetch latency is 1 edge from mem_ready=1 to if_valid=1.
- Branch penalty: branch asserted at edge N gives if_valid=0 after N. The target instruction is valid after N+1 if mem_ready=1.
- Freeze release from HOLD: if_valid=1 with the buffered word after the releasing edge. Fetch restarts the following cycle, so exactly one cycle has mem_req=0.
- mem_addr and mem_req come from registers/state only, with no combinational path from inputs.

## Configuration

IFU_PERF_CNT_EN selects whether performance counters are built.

- Defined:
  - adds outputs fetch_count[31:0] and stall_count[31:0], both reset to 0;
  - fetch_count increments on each word accepted into if_* or the buffer;
  - stall_count increments each cycle with mem_req=1 and mem_ready=0, or with state HOLD;
  - both counters wrap at 2^32.
- Undefined: the counter ports and logic are absent. All other behaviour is identical.

## Test plan

- **Reset/straight-line:** RESET_PC=0, mem_ready=1, memory returns addr-dependent words. Required: mem_addr 0,4,8,...; if_pc 4,8,12,...; if_valid=1 from edge 1 onward.
- **Wait states:** mem_ready low for 2 cycles at addr 8. Required: two bubbles (if_valid=0), mem_addr held at 8; the word at 8 is delivered with if_pc=12.
- **Freeze:** freeze high 3 cycles while the word at 12 returns. Required: state HOLD, mem_req=0, if_* unchanged; on release, if_pc=16 and fetch resumes at 16.
- **Branch:** branch_taken with branch_addr=32'h41 during a freeze in HOLD. Required: if_valid=0 next cycle, buffer dropped, mem_addr=32'h40; the next if_pc=32'h44.
- **Wrap and reset:**
  - RESET_PC=32'hFFFF_FFFC gives mem_addr FFFF_FFFC, then 0.
  - Asserting rst_n low mid-wait returns all outputs to reset values within the same cycle.
- **IFU_PERF_CNT_EN defined:** run the wait-state + freeze sequence. Required: stall_count=5 and fetch_count equals the number of accepted words.
